// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, FSM states and
// datapath mux select codes.
package mips_pkg;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_ADDI_WB  = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_JAL      = 4'd11;
    localparam logic [3:0] S_JR       = 4'd12;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_A      = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_perf_counters.sv
// Free-running cycle counter and retired-instruction counter; both wrap silently.
module mips_perf_counters #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    localparam logic [CNT_W-1:0] One = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_count <= '0;
            instret     <= '0;
        end else begin
            cycle_count <= cycle_count + One;
            if (retire) begin
                instret <= instret + One;
            end
        end
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives the shared-ALU datapath muxes and enables.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned CNT_W         = 32,
    parameter bit          MEM_HANDSHAKE = 1'b1,
    parameter bit          JAL_EN        = 1'b1,
    parameter bit          JR_EN         = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);

    logic [3:0] state, state_next;
    logic       ready;
    logic       pc_en_c, mem_read_c, mem_write_c, ir_write_c, reg_write_c;
    logic       instr_done_c, illegal_c;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    always_comb begin
        state_next   = state;
        pc_en_c      = 1'b0;
        iord         = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst      = RD_RT;
        mem_to_reg   = M2R_ALU;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        alu_op       = ALU_ADD;
        pc_source    = PC_ALU;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        case (state)
            S_FETCH: begin
                mem_read_c = 1'b1;
                alu_src_b  = SRCB_4;
                ir_write_c = ready;
                pc_en_c    = ready;
                if (ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut regardless of opcode.
                alu_src_b  = SRCB_IMM_SH;
                state_next = S_FETCH;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_ADDI:      state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_R: begin
                        if (funct != FN_JR) state_next = S_EXEC;
                        else if (JR_EN)     state_next = S_JR;
                        else                illegal_c  = 1'b1;
                    end
                    OP_JAL: begin
                        if (JAL_EN) state_next = S_JAL;
                        else        illegal_c  = 1'b1;
                    end
                    default: illegal_c = 1'b1;
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                iord       = 1'b1;
                mem_read_c = 1'b1;
                if (ready) state_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg   = M2R_MDR;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEM_WR: begin
                iord        = 1'b1;
                mem_write_c = 1'b1;
                if (ready) begin
                    instr_done_c = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                if (opcode == OP_ADDI) begin
                    alu_src_b  = SRCB_IMM;
                    state_next = S_ADDI_WB;
                end else begin
                    alu_op     = ALU_FUNCT;
                    state_next = S_R_WB;
                end
            end
            S_R_WB: begin
                reg_write_c  = 1'b1;
                reg_dst      = RD_RD;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            S_ADDI_WB: begin
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_source    = PC_ALUOUT;
                pc_en_c      = alu_zero;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            S_JUMP: begin
                pc_source    = PC_JUMP;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            S_JAL: begin
                // PC already holds PC+4 here, so the link value comes straight from PC.
                pc_source    = PC_JUMP;
                pc_en_c      = 1'b1;
                reg_write_c  = 1'b1;
                reg_dst      = RD_RA;
                mem_to_reg   = M2R_PC;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            S_JR: begin
                pc_source    = PC_A;
                pc_en_c      = 1'b1;
                instr_done_c = 1'b1;
                state_next   = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Reset must suppress every side effect in the same cycle it is asserted.
    assign pc_en      = pc_en_c      & ~reset;
    assign mem_read   = mem_read_c   & ~reset;
    assign mem_write  = mem_write_c  & ~reset;
    assign ir_write   = ir_write_c   & ~reset;
    assign reg_write  = reg_write_c  & ~reset;
    assign instr_done = instr_done_c & ~reset;
    assign illegal    = illegal_c    & ~reset;

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    mips_perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf_counters (
        .clk        (clk),
        .reset      (reset),
        .retire     (instr_done),
        .cycle_count(cycle_count),
        .instret    (instret)
    );

endmodule
